// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit that owns the HI/LO register pair for the EX stage.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both retire one bit
//   per clock. MTHI/MTLO write HI/LO directly. MFHI/MFLO read hi/lo, and EX is
//   stalled while an operation is in flight.
//
//   Ports
//     CLK     in   1      clock, posedge
//     RST     in   1      asynchronous active-low reset
//     start   in   1      issue request, accepted only when idle
//     op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//     rs      in   WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
//     rt      in   WIDTH  operand B (multiplier / divisor)
//     mf_req  in   1      EX is executing MFHI/MFLO this cycle
//     busy    out  1      mult/div in progress
//     stall   out  1      mf_req & busy
//     done    out  1      one-cycle pulse, hi/lo hold the new result
//     div0    out  1      pulses with done when the divisor was zero
//     hi, lo  out  WIDTH  HI/LO registers
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; serves MTHI/MTLO
//   MUL   | shift-add iteration, one multiplier bit per cycle
//   DIV   | restoring-divide iteration, one quotient bit per cycle
//   FIX   | sign correction and hi/lo commit
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opb;      // multiplicand (MUL) or divisor (DIV), magnitude
    logic [WIDTH-1:0]   dvd_raw;  // unmodified dividend, returned in hi on divide-by-zero
    logic               sign_q;   // product / quotient is negative
    logic               sign_r;   // remainder takes the dividend sign
    logic               is_div;
    logic               dz;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               borrow;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand conditioning and one iteration of each algorithm
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        abs_rs    = (signed_op && rs[WIDTH-1]) ? -rs : rs;
        abs_rt    = (signed_op && rt[WIDTH-1]) ? -rt : rt;

        // The sum keeps its carry bit, which shifts into the top of the product
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:1]};

        // The remainder shifted left needs WIDTH+1 bits before the trial subtract
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        borrow    = rem_sh < {1'b0, opb};
        div_diff  = rem_sh[WIDTH-1:0] - opb;
        div_next  = borrow ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {div_diff, acc[WIDTH-2:0], 1'b1};

        prod_fix  = sign_q ? -acc : acc;
        quo_fix   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && (op == OP_MULT || op == OP_MULTU))   state_nxt = S_MUL;
                else if (start && (op == OP_DIV || op == OP_DIVU)) state_nxt = S_DIV;
            end
            S_MUL:   if (count == LAST) state_nxt = S_FIX;
            S_DIV:   if (count == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; the FIX cycle still counts as busy because hi/lo are not yet committed
    always_comb begin
        busy  = (state != S_IDLE);
        stall = mf_req & busy;
    end

    // Datapath and HI/LO
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count   <= '0;
            acc     <= '0;
            opb     <= '0;
            dvd_raw <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, abs_rt};
                                opb    <= abs_rs;
                                sign_q <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                                sign_r <= 1'b0;
                                is_div <= 1'b0;
                                dz     <= 1'b0;
                                count  <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {{WIDTH{1'b0}}, abs_rs};
                                opb     <= abs_rt;
                                dvd_raw <= rs;
                                sign_q  <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                                sign_r  <= signed_op & rs[WIDTH-1];
                                is_div  <= 1'b1;
                                dz      <= (rt == '0);
                                count   <= '0;
                            end
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (dz) begin
                        hi <= dvd_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    div0  <= is_div & dz;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        mf_req;
    logic        busy, stall, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .mf_req (mf_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a one-cycle start at a negedge; returns at the negedge after the start edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge CLK);
        start = 1'b0;
        op    = 3'd6;
    endtask

    // Count cycles with busy high, bounded; ends in the cycle after busy drops
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        issue(o, a, b);
        wait_idle(n);
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_div0"}, 64'(div0), 64'(exp_dz));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 64'({done, div0}), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] hi_prev;

        RST    = 1'b0;
        start  = 1'b0;
        op     = 3'd6;
        rs     = '0;
        rt     = '0;
        mf_req = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_hi",   64'(hi), 64'd0);
        chk("rst_lo",   64'(lo), 64'd0);
        chk("rst_ctrl", 64'({busy, stall, done, div0}), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        // MTHI / MTLO in idle: immediate write, no done
        issue(3'd4, 32'h1111_2222, 32'h0);
        chk("mthi_hi", 64'(hi), 64'h1111_2222);
        chk("mthi_nodone", 64'({busy, done}), 64'd0);
        issue(3'd5, 32'h3333_4444, 32'h0);
        chk("mtlo_lo", 64'(lo), 64'h3333_4444);
        chk("mtlo_hi_kept", 64'(hi), 64'h1111_2222);

        // No-op codes leave everything alone
        issue(3'd6, 32'hFFFF_FFFF, 32'h1);
        issue(3'd7, 32'hFFFF_FFFF, 32'h1);
        chk("nop_state", 64'({busy, done, hi, lo}), {2'b00, 32'h1111_2222, 32'h3333_4444});

        run_check("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_check("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_check("mult_negneg", 3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30, 1'b0);
        run_check("multu_hi", 3'd1, 32'h8000_0000, 32'd4, 32'h2, 32'h0, 1'b0);
        run_check("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("div_7dm2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_check("divu_100d7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_check("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        run_check("divu_by0", 3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_check("div_by0", 3'd2, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
        run_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        // MULT 1000 * -2 with an MTHI attempt while busy and mf_req from cycle 10
        hi_prev = hi;
        issue(3'd0, 32'd1000, 32'hFFFF_FFFE);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 5) begin
                chk("stall_before_mf", 64'(stall), 64'd0);
                start = 1'b1;
                op    = 3'd4;
                rs    = 32'hDEAD_BEEF;
            end
            if (n == 6) begin
                start = 1'b0;
                op    = 3'd6;
                chk("mthi_busy_ignored", 64'(hi), 64'(hi_prev));
            end
            if (n == 9) mf_req = 1'b1;
            if (n >= 10) chk($sformatf("stall_c%0d", n), 64'(stall), 64'd1);
            if (n == 20) chk("hi_hold_mid", 64'({hi, lo}), {hi_prev, 32'h8000_0000});
            @(negedge CLK);
        end
        chk("mf_busy_cycles", 64'(n), 64'd33);
        chk("mf_done", 64'(done), 64'd1);
        chk("mf_done_nostall", 64'(stall), 64'd0);
        chk("mf_result", 64'({hi, lo}), {32'hFFFF_FFFF, 32'hFFFF_F830});
        mf_req = 1'b0;
        @(negedge CLK);

        // Asynchronous reset in the middle of an operation
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        n = 0;
        while (busy && n < 15) begin
            n++;
            if (n < 15) @(negedge CLK);
        end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 RST = 1'b0;
        #1;
        chk("midrst_hilo", 64'({hi, lo}), 64'd0);
        chk("midrst_ctrl", 64'({busy, stall, done, div0}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        issue(3'd5, 32'h0000_00A5, 32'h0);
        chk("post_rst_mtlo", 64'(lo), 64'h0000_00A5);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_idle", 64'({busy, done}), 64'd0);

        // A full operation still works after the reset
        run_check("post_rst_divu", 3'd3, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
